fft_out_collector: RTL

FFT_OUT_COLLECTOR -- requirements
Module: fft_out_collector

---
 rtl/fft_out_collector.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/fft_out_collector.sv
// fft_out_collector
//   Collects one frame of bit-reversed FFT output into an N-entry complex
//   buffer (N = 2**LAYER) and replays it in natural order over a
//   valid/ready stream.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous active-low reset
//   start_next : first sample of a frame is on in_real/in_img this cycle
//   end_next   : last sample of a frame is on in_real/in_img this cycle
//   in_real    : FFT real part, one sample per cycle while capturing
//   in_img     : FFT imaginary part
//   out_ready  : downstream accepts the current output sample
//   out_valid  : out_real/out_img/out_last hold a valid sample
//   out_real   : natural-order real part
//   out_img    : natural-order imaginary part
//   out_last   : marks sample index N-1
//   busy       : high while capturing or draining
//   frame_err  : sticky, a framing violation was seen
//   overrun    : sticky, a frame started while the previous one drained
module fft_out_collector #(
  parameter int LAYER = 10,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_next,
  input  logic          end_next,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_img,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_real,
  output logic [DW-1:0] out_img,
  output logic          out_last,
  output logic          busy,
  output logic          frame_err,
  output logic          overrun
);

  localparam int N = 1 << LAYER;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  localparam logic [LAYER-1:0] ADDR_ZERO = {LAYER{1'b0}};
  localparam logic [LAYER-1:0] ADDR_ONE  = LAYER'(1'b1);
  localparam logic [LAYER-1:0] ADDR_LAST = {LAYER{1'b1}};
  localparam logic [LAYER:0]   RD_ZERO   = {(LAYER+1){1'b0}};
  localparam logic [LAYER:0]   RD_ONE    = (LAYER+1)'(1'b1);

  // Reverse the LAYER address bits: FFT emits sample k for bin bitrev(k).
  function automatic logic [LAYER-1:0] bitrev(input logic [LAYER-1:0] a);
    logic [LAYER-1:0] r;
    for (int i = 0; i < LAYER; i++) begin
      r[i] = a[LAYER-1-i];
    end
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [LAYER-1:0] wr_cnt_q, wr_cnt_d;
  // rd_cnt_q[LAYER] flags that every address has already been read.
  logic [LAYER:0]  rd_cnt_q, rd_cnt_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic [DW-1:0]   out_real_q, out_real_d;
  logic [DW-1:0]   out_img_q, out_img_d;
  logic            busy_q, busy_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;

  logic             wr_en_s;
  logic [LAYER-1:0] wr_addr_s;
  logic [LAYER-1:0] rd_addr_s;
  logic [2*DW-1:0]  rd_data_s;
  logic             xfer_s;
  logic             load_s;

  logic [2*DW-1:0] mem_q [N];

  // Next-state, buffer write control and output-register load decisions.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_real_d  = out_real_q;
    out_img_d   = out_img_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    wr_en_s     = 1'b0;
    wr_addr_s   = ADDR_ZERO;
    rd_addr_s   = rd_cnt_q[LAYER-1:0];
    rd_data_s   = mem_q[rd_addr_s];
    xfer_s      = out_valid_q & out_ready;
    // The output register is the read register: refill when empty or taken.
    load_s      = (~out_valid_q | out_ready) & ~rd_cnt_q[LAYER];

    case (state_q)
      IDLE: begin
        if (start_next) begin
          wr_en_s   = 1'b1;
          wr_addr_s = ADDR_ZERO;
          wr_cnt_d  = ADDR_ONE;
          state_d   = CAPTURE;
        end else begin
          wr_cnt_d  = ADDR_ZERO;
        end
      end

      CAPTURE: begin
        if (end_next) begin
          if (wr_cnt_q == ADDR_LAST) begin
            wr_en_s   = 1'b1;
            wr_addr_s = bitrev(wr_cnt_q);
            rd_cnt_d  = RD_ZERO;
            state_d   = DRAIN;
          end else begin
            frame_err_d = 1'b1;
            wr_cnt_d    = ADDR_ZERO;
            state_d     = IDLE;
          end
        end else if (start_next) begin
          // Unexpected restart: the new frame replaces the partial one.
          frame_err_d = 1'b1;
          wr_en_s     = 1'b1;
          wr_addr_s   = ADDR_ZERO;
          wr_cnt_d    = ADDR_ONE;
        end else if (wr_cnt_q == ADDR_LAST) begin
          frame_err_d = 1'b1;
          wr_cnt_d    = ADDR_ZERO;
          state_d     = IDLE;
        end else begin
          wr_en_s   = 1'b1;
          wr_addr_s = bitrev(wr_cnt_q);
          wr_cnt_d  = wr_cnt_q + ADDR_ONE;
        end
      end

      DRAIN: begin
        if (start_next) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end

        if (xfer_s && out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          rd_cnt_d    = RD_ZERO;
          wr_cnt_d    = ADDR_ZERO;
          state_d     = IDLE;
        end else if (load_s) begin
          out_valid_d = 1'b1;
          out_last_d  = (rd_addr_s == ADDR_LAST);
          out_real_d  = rd_data_s[2*DW-1:DW];
          out_img_d   = rd_data_s[DW-1:0];
          rd_cnt_d    = rd_cnt_q + RD_ONE;
        end else if (xfer_s) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_cnt_q    <= ADDR_ZERO;
      rd_cnt_q    <= RD_ZERO;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_real_q  <= {DW{1'b0}};
      out_img_q   <= {DW{1'b0}};
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_real_q  <= out_real_d;
      out_img_q   <= out_img_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Frame buffer write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_addr_s] <= {in_real, in_img};
    end
  end

  assign out_valid = out_valid_q;
  assign out_real  = out_real_q;
  assign out_img   = out_img_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
